// File: rtl/rs_pkg.sv
// Shared constants and types for the RS decoder symbol delay path.
package rs_pkg;

    localparam int RS_SYM_W  = 8;
    localparam int RS_N      = 255;
    localparam int RS_ADDR_W = 8;

    typedef logic [RS_SYM_W-1:0]  rs_sym_t;
    typedef logic [RS_ADDR_W-1:0] rs_ptr_t;
    typedef logic [RS_ADDR_W:0]   rs_occ_t;

endpackage : rs_pkg

// File: rtl/rs_delay_corrector_if.sv
// Bus between the delay corrector and the dual-port symbol delay RAM.
// master: the corrector (drives write and read requests); slave: the RAM.
interface rs_delay_corrector_if import rs_pkg::*; #(
    parameter int SYM_W  = RS_SYM_W,
    parameter int ADDR_W = RS_ADDR_W
);

    logic [SYM_W-1:0]  ram_data;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddress;
    logic [ADDR_W-1:0] ram_rdaddress;
    logic              ram_rden;
    logic [SYM_W-1:0]  ram_q;

    modport master (
        output ram_data, ram_wren, ram_wraddress, ram_rdaddress, ram_rden,
        input  ram_q
    );

    modport slave (
        input  ram_data, ram_wren, ram_wraddress, ram_rdaddress, ram_rden,
        output ram_q
    );

endinterface : rs_delay_corrector_if

// File: rtl/rs_align_pipe.sv
// Fixed-depth shift register that delays per-beat side information
// ({valid, sop, eop, err_mag}) so it lines up with the RAM read data.
module rs_align_pipe #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    // Shift one stage per clock; every stage clears on reset.
    // NOTE: this small array is reset deliberately so no stale beat can emerge
    // after reset; the delay RAM is not reset, occupancy keeps it from being read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule : rs_align_pipe

// File: rtl/rs_delay_corrector.sv
// RS decoder symbol delay corrector: buffers received symbols in the delay
// RAM, replays them against the Forney error-magnitude stream and emits the
// corrected codeword with sop/eop markers.
// Optional build macro RS_CORR_STATS_EN adds a per-codeword count of
// corrected symbols on corr_count; without it corr_count is tied to 0.
module rs_delay_corrector import rs_pkg::*; #(
    parameter int SYM_W  = RS_SYM_W,
    parameter int ADDR_W = RS_ADDR_W,
    parameter int N      = RS_N,
    parameter int RD_LAT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SYM_W-1:0]     in_sym,
    input  logic                 in_valid,
    input  logic                 in_sop,
    rs_delay_corrector_if.master ram,
    input  logic [SYM_W-1:0]     err_mag,
    input  logic                 err_valid,
    output logic                 err_ready,
    output logic [SYM_W-1:0]     out_sym,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 overflow,
    output logic                 frame_err,
    output logic [ADDR_W-1:0]    corr_count
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam int                PIPE_W   = SYM_W + 3;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic [ADDR_W:0]   occ;
    logic              full, wr_en, accept;

    logic [PIPE_W-1:0] pipe_din, pipe_dout;
    logic              d_valid, d_sop, d_eop;
    logic [SYM_W-1:0]  d_mag;

    // Request side is combinational from registered occupancy, so a symbol
    // written this cycle becomes readable on the next one at the earliest.
    assign full      = (occ == DEPTH);
    assign wr_en     = in_valid & ~full;
    assign err_ready = (occ != '0);
    assign accept    = err_valid & err_ready;

    assign ram.ram_wren      = wr_en;
    assign ram.ram_data      = in_sym;
    assign ram.ram_wraddress = wr_ptr;
    assign ram.ram_rden      = accept;
    assign ram.ram_rdaddress = rd_ptr;

    // Circular RAM pointers and occupancy; simultaneous write and accept cancel.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + ADDR_W'(1);
            if (accept) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, accept})
                2'b10:   occ <= occ + (ADDR_W+1)'(1);
                2'b01:   occ <= occ - (ADDR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Input framing: write index advances on every valid symbol (even a dropped
    // one), resynchronises on sop, and latches the sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx    <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (in_valid) begin
            if (full)                     overflow  <= 1'b1;
            if (in_sop && wr_idx != '0)   frame_err <= 1'b1;
            if (in_sop)                   wr_idx    <= ADDR_W'(1);
            else if (wr_idx == LAST_IDX)  wr_idx    <= '0;
            else                          wr_idx    <= wr_idx + ADDR_W'(1);
        end
    end

    // Read index tracks the position of each accepted symbol within its codeword.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     rd_idx <= '0;
        else if (accept) begin
            if (rd_idx == LAST_IDX)    rd_idx <= '0;
            else                       rd_idx <= rd_idx + ADDR_W'(1);
        end
    end

    // Markers are qualified by accept so idle cycles carry an all-zero beat.
    assign pipe_din = {accept,
                       accept & (rd_idx == '0),
                       accept & (rd_idx == LAST_IDX),
                       err_mag};

    rs_align_pipe #(
        .W     (PIPE_W),
        .DEPTH (RD_LAT)
    ) u_align (
        .clock (clock),
        .reset (reset),
        .din   (pipe_din),
        .dout  (pipe_dout)
    );

    assign {d_valid, d_sop, d_eop, d_mag} = pipe_dout;

    // Output register: apply the delayed error magnitude to the replayed symbol.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_sym   <= '0;
        end else begin
            out_valid <= d_valid;
            out_sop   <= d_sop;
            out_eop   <= d_eop;
            out_sym   <= d_valid ? (ram.ram_q ^ d_mag) : '0;
        end
    end

`ifdef RS_CORR_STATS_EN
    logic [ADDR_W-1:0] corr_acc;
    logic              corr_hit;

    assign corr_hit = d_valid & (d_mag != '0);

    // Count corrected beats; publish the total (including the eop beat) at eop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            corr_acc   <= '0;
            corr_count <= '0;
        end else if (d_valid && d_eop) begin
            corr_count <= corr_acc + ADDR_W'(corr_hit);
            corr_acc   <= '0;
        end else if (corr_hit) begin
            corr_acc   <= corr_acc + ADDR_W'(1);
        end
    end
`else
    assign corr_count = '0;
`endif

endmodule : rs_delay_corrector

// File: tb/tb_rs_delay_corrector.sv
// Self-checking bench for rs_delay_corrector. Holds a behavioural RAM with
// RD_LAT read latency and a queue-based reference model of the corrector.
module tb_rs_delay_corrector;
    import rs_pkg::*;

    localparam int RD_LAT = 2;
    localparam int N      = RS_N;
    localparam int DEPTH  = 1 << RS_ADDR_W;

    typedef struct {
        int      due;
        rs_sym_t sym;
        bit      sop;
        bit      eop;
        bit      nz;
    } exp_t;

    logic    clock = 1'b0;
    logic    reset = 1'b0;
    rs_sym_t in_sym = '0;
    logic    in_valid = 1'b0;
    logic    in_sop = 1'b0;
    rs_sym_t err_mag = '0;
    logic    err_valid = 1'b0;
    logic    err_ready;
    rs_sym_t out_sym;
    logic    out_valid, out_sop, out_eop;
    logic    overflow, frame_err;
    rs_ptr_t corr_count;

    rs_delay_corrector_if #(.SYM_W(RS_SYM_W), .ADDR_W(RS_ADDR_W)) ram_bus ();

    rs_delay_corrector #(
        .SYM_W (RS_SYM_W), .ADDR_W (RS_ADDR_W), .N (N), .RD_LAT (RD_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_sym     (in_sym),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .ram        (ram_bus),
        .err_mag    (err_mag),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .out_sym    (out_sym),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .corr_count (corr_count)
    );

    always #5 clock = ~clock;

    // Behavioural delay RAM
    rs_sym_t mem [DEPTH];
    rs_sym_t q_stage [RD_LAT];
    initial foreach (mem[i]) mem[i] = '0;
    always @(posedge clock) begin
        if (ram_bus.ram_wren) mem[ram_bus.ram_wraddress] <= ram_bus.ram_data;
        q_stage[0] <= ram_bus.ram_rden ? mem[ram_bus.ram_rdaddress] : '0;
        for (int i = 1; i < RD_LAT; i++) q_stage[i] <= q_stage[i-1];
    end
    assign ram_bus.ram_q = q_stage[RD_LAT-1];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state
    int      n_assert = 0;
    int      n_fail   = 0;
    int      m_occ, m_widx, m_ridx, m_cnt;
    bit      m_ovf, m_ferr;
    rs_ptr_t m_corr;
    rs_sym_t sym_q [$];
    exp_t    exp_q [$];
    rs_sym_t mags  [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        bit   due;
        due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("out_valid", 32'(out_valid), 32'(due));
        if (due) begin
            e = exp_q.pop_front();
            chk("out_sym", 32'(out_sym), 32'(e.sym));
            chk("out_sop", 32'(out_sop), 32'(e.sop));
            chk("out_eop", 32'(out_eop), 32'(e.eop));
            if (e.nz) m_cnt++;
            if (e.eop) begin
`ifdef RS_CORR_STATS_EN
                m_corr = rs_ptr_t'(m_cnt);
`endif
                m_cnt = 0;
            end
        end else begin
            chk("out_sop_idle", 32'(out_sop), 32'd0);
            chk("out_eop_idle", 32'(out_eop), 32'd0);
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("corr_count", 32'(corr_count), 32'(m_corr));
    endtask

    // One clock of stimulus; starts and ends at a falling edge.
    task automatic cycle(input bit iv, input bit isop, input rs_sym_t isym,
                         input bit ev, input rs_sym_t emag);
        bit   acc, wr;
        exp_t e;
        in_valid = iv; in_sop = isop; in_sym = isym;
        err_valid = ev; err_mag = emag;
        #1;
        acc = ev && (m_occ != 0);
        wr  = iv && (m_occ < DEPTH);
        chk("err_ready", 32'(err_ready), 32'(m_occ != 0));
        chk("ram_wren", 32'(ram_bus.ram_wren), 32'(wr));
        chk("ram_rden", 32'(ram_bus.ram_rden), 32'(acc));
        if (acc) begin
            e.due = cyc + RD_LAT + 1;
            e.sym = sym_q.pop_front() ^ emag;
            e.sop = (m_ridx == 0);
            e.eop = (m_ridx == N - 1);
            e.nz  = (emag != 0);
            exp_q.push_back(e);
            m_ridx = (m_ridx + 1) % N;
        end
        if (wr) sym_q.push_back(isym);
        if (iv) begin
            if (!wr) m_ovf = 1'b1;
            if (isop && m_widx != 0) m_ferr = 1'b1;
            m_widx = isop ? 1 : (m_widx + 1) % N;
        end
        m_occ = m_occ + int'(wr) - int'(acc);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit ev);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, ev, '0);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_sym = '0;
        err_valid = 1'b0; err_mag = '0;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sop", 32'(out_sop), 32'd0);
        chk("rst_out_eop", 32'(out_eop), 32'd0);
        chk("rst_out_sym", 32'(out_sym), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_ready", 32'(err_ready), 32'd0);
        chk("rst_ram_wren", 32'(ram_bus.ram_wren), 32'd0);
        chk("rst_ram_rden", 32'(ram_bus.ram_rden), 32'd0);
        chk("rst_wraddress", 32'(ram_bus.ram_wraddress), 32'd0);
        chk("rst_rdaddress", 32'(ram_bus.ram_rdaddress), 32'd0);
        chk("rst_corr_count", 32'(corr_count), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_occ = 0; m_widx = 0; m_ridx = 0; m_cnt = 0;
        m_ovf = 1'b0; m_ferr = 1'b0; m_corr = '0;
        sym_q.delete();
        exp_q.delete();
    endtask

    function automatic rs_sym_t rand_mag();
        return ($urandom_range(0, 3) == 0) ? rs_sym_t'($urandom) : '0;
    endfunction

    initial begin
        #2;
        apply_reset();

        // Empty: requests with nothing stored are refused
        idle(3, 1'b1);
        cycle(1'b1, 1'b1, 8'h5A, 1'b1, 8'h0F);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'h0F);
        idle(RD_LAT + 3, 1'b0);

        // Single codeword: symbols 0..254, errors at 3 (FF) and 254 (01)
        apply_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, i == 0, rs_sym_t'(i), 1'b0, '0);
        for (int i = 0; i < N; i++)
            cycle(1'b0, 1'b0, '0, 1'b1, (i == 3) ? 8'hFF : (i == 254) ? 8'h01 : 8'h00);
        idle(RD_LAT + 3, 1'b0);

        // Concurrent read/write: codewords 2 and 3 stream in while 1 and 2 stream out
        apply_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, i == 0, rs_sym_t'($urandom), 1'b0, '0);
        for (int j = 0; j < 2 * N; j++)
            cycle(1'b1, (j % N) == 0, rs_sym_t'($urandom), 1'b1, rand_mag());
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, '0, 1'b1, rand_mag());
        idle(RD_LAT + 3, 1'b0);

        // Full: 260 writes without reads, then drain 256 and keep requesting
        apply_reset();
        for (int i = 0; i < 260; i++)
            cycle(1'b1, (i % N) == 0, rs_sym_t'(i), 1'b0, '0);
        for (int i = 0; i < 260; i++) cycle(1'b0, 1'b0, '0, 1'b1, rand_mag());
        idle(RD_LAT + 3, 1'b0);

        // Framing: clean wrap at N, then a misplaced sop at write index 100
        apply_reset();
        for (int i = 0; i < N + 100; i++)
            cycle(1'b1, (i % N) == 0, rs_sym_t'($urandom), 1'b1, '0);
        cycle(1'b1, 1'b1, 8'hC3, 1'b1, '0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, rs_sym_t'($urandom), 1'b1, '0);
        idle(RD_LAT + 3, 1'b1);

        // Random traffic with occasional rogue sops and overflow pressure
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            bit iv, sp, ev;
            iv = ($urandom_range(0, 3) != 0);
            sp = iv && ((m_widx == 0) || ($urandom_range(0, 199) == 0));
            ev = (i > 600) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            cycle(iv, sp, rs_sym_t'($urandom), ev, rand_mag());
        end
        idle(RD_LAT + 3, 1'b0);

        // Reset mid-read at beat 50, then restart cleanly
        apply_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, i == 0, rs_sym_t'($urandom), 1'b0, '0);
        for (int i = 0; i <= 50; i++) cycle(1'b0, 1'b0, '0, 1'b1, rand_mag());
        apply_reset();
        idle(10, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, rs_sym_t'($urandom), 1'b1, rand_mag());
        idle(5, 1'b1);
        idle(RD_LAT + 3, 1'b0);

        // Seven nonzero magnitudes in one codeword, one on the eop beat
        apply_reset();
        foreach (mags[i]) mags[i] = '0;
        mags[0] = 8'h11; mags[10] = 8'h22; mags[77] = 8'h33; mags[128] = 8'h44;
        mags[200] = 8'h55; mags[253] = 8'h66; mags[254] = 8'h77;
        for (int i = 0; i < N; i++) cycle(1'b1, i == 0, rs_sym_t'($urandom), 1'b0, '0);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, '0, 1'b1, mags[i]);
        idle(RD_LAT + 3, 1'b0);
`ifdef RS_CORR_STATS_EN
        chk("corr_count_7", 32'(corr_count), 32'd7);
`endif

        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rs_delay_corrector

// File: doc/rs_delay_corrector.md
Name: rs_delay_corrector

Overview:
- Wraps the RS decoder's 256x8 dual-port symbol delay RAM.
- Write side: streams received symbols into the RAM while syndrome, key-equation and Chien/Forney stages run.
- Read side: replays each stored symbol in lock-step with the per-symbol error magnitude stream from Forney, XORs the two, and emits the corrected codeword stream with frame markers.
- Sits between the receive input/Forney output and the decoder's output interface; it is the RAM's only producer and consumer.

Parameters:
- SYM_W, 8, symbol width in bits (matches RAM data/q).
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W.
- N, 255, codeword length in symbols; legal range 2..2^ADDR_W.
- RD_LAT, 2, cycles from ram_rden high to valid ram_q; legal range 1..4.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- in_sym, in, SYM_W: received symbol.
- in_valid, in, 1: in_sym valid this cycle.
- in_sop, in, 1: first symbol of a codeword; qualified by in_valid.
- ram_data, out, SYM_W: RAM write data.
- ram_wren, out, 1: RAM write enable.
- ram_wraddress, out, ADDR_W: RAM write address.
- ram_rdaddress, out, ADDR_W: RAM read address.
- ram_rden, out, 1: RAM read enable.
- ram_q, in, SYM_W: RAM read data.
- err_mag, in, SYM_W: error magnitude for the next symbol in codeword order; 0 means no error.
- err_valid, in, 1: err_mag valid.
- err_ready, out, 1: block accepts err_mag this cycle.
- out_sym, out, SYM_W: corrected symbol.
- out_valid, out, 1: out_sym valid.
- out_sop, out, 1: first symbol of output codeword.
- out_eop, out, 1: last symbol of output codeword.
- overflow, out, 1: sticky; a symbol was dropped because the RAM was full.
- frame_err, out, 1: sticky; in_sop arrived at a nonzero write index.
- corr_count, out, ADDR_W: symbols corrected in the last codeword (optional feature only).

Behaviour:
- Reset: all outputs 0. wr_ptr, rd_ptr, occupancy (ADDR_W+1 bits), write index and read index cleared. Alignment pipe flushed. Reset mid-codeword abandons all stored data; no partial output after reset release.
- Write path is purely combinational from registered state:
  - ram_wren = in_valid & ~full; ram_data = in_sym; ram_wraddress = wr_ptr.
  - wr_ptr increments mod 2^ADDR_W on each write.
  - full = (occupancy == 2^ADDR_W).
- Full: the symbol is dropped, overflow sets, and the write index still advances so framing is preserved.
- Write index counts 0..N-1 and wraps to 0. If in_valid & in_sop while index != 0: set frame_err, write the symbol, next index = 1.
- Read accept:
  - err_ready = (occupancy != 0), using registered occupancy. A symbol written in cycle t is readable at t+1 at the earliest.
  - Accept = err_valid & err_ready, which drives ram_rden = 1 with ram_rdaddress = rd_ptr. rd_ptr then increments mod 2^ADDR_W.
- Occupancy: +1 on write, -1 on accept, unchanged when both occur in the same cycle.
- Alignment:
  - err_mag, valid, sop = (read index == 0) and eop = (read index == N-1) are delayed RD_LAT cycles in the alignment pipe.
  - At pipe output: out_sym = ram_q ^ delayed err_mag, registered. Total latency from accept to out_valid is RD_LAT+1 cycles.
  - Read index counts 0..N-1 and wraps.
- The pipeline never stalls; the downstream consumer must always accept.
- Back-to-back codewords run at full rate with no bubble between eop and the next sop.
- overflow and frame_err clear only on reset.

Optional Feature:
- Macro: RS_CORR_STATS_EN.
- Defined: a counter increments on each output beat with nonzero delayed err_mag. On the out_eop beat, corr_count loads the final count, including that beat. The counter then clears. corr_count holds its value until the next eop.
- Undefined: the counter is not built and corr_count is tied to 0.

Decomposition:
- Package rs_pkg holds:
  - constants RS_SYM_W = 8, RS_N = 255, RS_ADDR_W = 8;
  - typedef rs_sym_t (SYM_W vector);
  - typedef rs_ptr_t (ADDR_W vector);
  - typedef rs_occ_t (ADDR_W+1 vector).
- Sub-module rs_align_pipe: an RD_LAT-deep shift register carrying {valid, sop, eop, err_mag}, reset to 0. It is instantiated once.

Test Plan:
- Single codeword: write 255 symbols 0..254 with err_valid held at 0, then stream 255 err_mag values, all 0 except index 3 = 0xFF and index 254 = 0x01.
  - out_sym[3] = 0xFC; out_sym[254] = 0xFF; all others equal their input.
  - out_sop on beat 0 only; out_eop on beat 254 only.
  - First out_valid occurs RD_LAT+1 cycles after the first accept.
- Concurrent read and write: stream codeword 2 in while codeword 1 is read out.
  - Occupancy stays constant; outputs are continuous with no bubble; sop/eop recur every 255 beats.
- Full: write 257 symbols with no reads.
  - Symbols 257 and beyond are dropped (ram_wren = 0 on them); overflow = 1; err_ready stays 1 until 256 reads are done.
- Empty: assert err_valid with occupancy 0.
  - err_ready = 0 and ram_rden = 0.
  - Write one symbol: err_ready rises the following cycle.
- Framing: assert in_sop at write index 100.
  - frame_err = 1; the next symbol is written at write index 1.
- Reset mid-read: assert reset during a read of beat 50.
  - All outputs are 0 immediately; after release, no out_valid appears until new writes and accepts.
  - With RS_CORR_STATS_EN defined: 7 nonzero err_mag values in one codeword give corr_count = 7 at out_eop.
